// File: rtl/dmem_responder_pkg.sv
// Shared types and widths for the data-memory responder.
//   ADDR_W / DATA_W / BE_W : request/response bus widths
//   CNT_W                  : width of the wait-state counter (0..15)
//   state_t                : responder FSM states
package dmem_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between a core data port and the memory responder.
//   req_valid/req_ready : request handshake (master -> slave)
//   req_we/addr/wdata/be: request payload, valid with req_valid
//   rsp_valid/rsp_ready : response handshake (slave -> master)
//   rsp_rdata/rsp_err   : response payload, valid with rsp_valid
interface dmem_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder_array.sv
// Single-port word storage with per-byte write enables and a registered read.
//   clk     : clock
//   en_i    : access strobe (one access per asserted cycle)
//   we_i    : 1 = write enabled lanes, 0 = read full word
//   be_i    : byte-lane write enables
//   addr_i  : word index
//   wdata_i : write data, little-endian lanes
//   rdata_o : read data, updated only on read accesses and held otherwise
// Contents are not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  // One byte-wide RAM per lane so each lane infers a plain write-enabled block.
  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
    logic [7:0] mem_q [DEPTH_WORDS];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (en_i) begin
        if (we_i) begin
          if (be_i[gi]) begin
            mem_q[addr_i] <= wdata_i[8*gi +: 8];
          end
        end else begin
          rd_q <= mem_q[addr_i];
        end
      end
    end

    assign rdata_o[8*gi +: 8] = rd_q;
  end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked, wait-stated data memory for core loads and stores.
//   clk : clock, rising edge
//   rst : asynchronous reset, active-low
//   bus : dmem_if slave port (request in, response out)
// One request is taken in IDLE, held for WAIT_STATES cycles, then the access
// is made on the array and the result is offered until the initiator takes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              ready_q, ready_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_load_q, rsp_load_d;

  logic              accept;
  logic              ram_en;
  logic [DATA_W-1:0] ram_rdata;

  // Decode of the latched address. The 33-bit subtraction gives the
  // below-base test as its borrow bit.
  logic [32:0]       diff_w;
  logic [31:0]       idx_w;
  logic              dec_err;

  assign diff_w  = {1'b0, addr_q} - {1'b0, BASE_ADDR};
  assign idx_w   = diff_w[31:0] >> 2;
  assign dec_err = (addr_q[1:0] != 2'b00) | diff_w[32] | (idx_w >= 32'(DEPTH_WORDS));

  assign accept  = bus.req_valid && ready_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rsp_err_d  = rsp_err_q;
    rsp_load_d = rsp_load_q;
    ram_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d       = bus.req_we;
          addr_d     = bus.req_addr;
          wdata_d    = bus.req_wdata;
          be_d       = bus.req_be;
          cnt_d      = CNT_W'(WAIT_STATES);
          rsp_err_d  = 1'b0;
          rsp_load_d = 1'b0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Access edge: a faulting request never touches the array.
          ram_en     = !dec_err;
          rsp_err_d  = dec_err;
          rsp_load_d = !we_q && !dec_err;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered ready: low during reset, rises on the first edge after
    // release and then tracks IDLE.
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      ready_q    <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      ready_q    <= ready_d;
      rsp_err_q  <= rsp_err_d;
      rsp_load_q <= rsp_load_d;
    end
  end

  // The array's read register is the load-data response register: it is
  // only clocked on the access edge, so it holds through backpressure.
  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (we_q),
    .be_i    (be_q),
    .addr_i  (idx_w[AW-1:0]),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_load_q ? ram_rdata : '0;

endmodule
